// File: rtl/fc_sched_pkg.sv
// Shared types and derived constants for the fully-connected layer sequencer.
// N_BEAT and N_GRP describe the default build; n_beat()/n_grp() derive them for any parameter set.
package fc_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_FIN
  } state_e;

  localparam int DEF_INNEURON  = 800;
  localparam int DEF_OUTNEURON = 500;
  localparam int DEF_PO        = 10;

  localparam int N_BEAT = DEF_INNEURON / 2;
  localparam int N_GRP  = DEF_OUTNEURON / DEF_PO;

  function automatic int n_beat(input int inneuron);
    return inneuron / 2;
  endfunction

  function automatic int n_grp(input int outneuron, input int po);
    return outneuron / po;
  endfunction

endpackage

// File: rtl/fc_delay_line.sv
// Parameterised WIDTH x DEPTH shift register with asynchronous clear (DEPTH >= 1).
module fc_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: the stages carry control strobes, so they are cleared on reset; a stale
  // strobe surviving reset would fire a spurious accumulator load. Non-blocking
  // assignments let every stage sample its predecessor's old value on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fc_layer_sched.sv
// Fully-connected layer sequencer: issues neuron/weight reads per output group, drains, writes back.
// Optional macro FC_SCHED_PERF_EN adds the perf_cycles / perf_stalls counters.
module fc_layer_sched
  import fc_sched_pkg::*;
#(
  parameter int INNEURON  = DEF_INNEURON,
  parameter int OUTNEURON = DEF_OUTNEURON,
  parameter int PO        = DEF_PO,
  parameter int RD_LAT    = 2,
  parameter int ACC_LAT   = 1,
  parameter int IN_AW     = $clog2(INNEURON),
  parameter int WT_AW     = $clog2(n_beat(INNEURON) * n_grp(OUTNEURON, PO)),
  parameter int GRP_W     = $clog2(n_grp(OUTNEURON, PO) + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             wb_ready,
  output logic             in_rden,
  output logic [IN_AW-1:0] in_addr_a,
  output logic [IN_AW-1:0] in_addr_b,
  output logic             wt_rden,
  output logic [WT_AW-1:0] wt_addr,
  output logic             mac_valid,
  output logic             mac_sload,
  output logic             out_wr_en,
  output logic [GRP_W-1:0] out_addr,
  output logic             busy,
  output logic             done
`ifdef FC_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [15:0]      perf_stalls
`endif
);

  localparam int BEATS  = n_beat(INNEURON);
  localparam int GROUPS = n_grp(OUTNEURON, PO);
  localparam int DRN    = RD_LAT + ACC_LAT;
  localparam int DRN_W  = $clog2(DRN + 1);

  localparam logic [IN_AW-1:0] K_LAST   = IN_AW'(BEATS - 1);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRN - 1);

  state_e           state_q, state_d;
  logic [IN_AW-1:0] k_q, k_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic [IN_AW-1:0] a_hold_q, b_hold_q;
  logic [WT_AW-1:0] wt_hold_q;
  logic             issue;

  // NOTE: every always_comb output gets a default before the case, so no path
  // can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    grp_d   = grp_q;
    drn_d   = drn_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          k_d     = '0;
          grp_d   = '0;
        end
      end
      S_ISSUE: begin
        if (k_q == K_LAST) begin
          k_d     = '0;
          drn_d   = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + IN_AW'(1);
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_LAST) begin
          drn_d   = '0;
          state_d = S_WRITE;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      S_WRITE: begin
        if (wb_ready) begin
          if (grp_q == GRP_LAST) begin
            state_d = S_FIN;
          end else begin
            grp_d   = grp_q + GRP_W'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_FIN: begin
        grp_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      grp_q     <= '0;
      drn_q     <= '0;
      a_hold_q  <= '0;
      b_hold_q  <= '0;
      wt_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      grp_q     <= grp_d;
      drn_q     <= drn_d;
      a_hold_q  <= in_addr_a;
      b_hold_q  <= in_addr_b;
      wt_hold_q <= wt_addr;
    end
  end

  // Addresses follow the beat counter while issuing and freeze at the last issued value otherwise.
  assign issue     = (state_q == S_ISSUE);
  assign in_rden   = issue;
  assign wt_rden   = issue;
  assign in_addr_a = issue ? (k_q << 1) : a_hold_q;
  assign in_addr_b = issue ? ((k_q << 1) | IN_AW'(1)) : b_hold_q;
  assign wt_addr   = issue ? (WT_AW'(grp_q) * WT_AW'(BEATS) + WT_AW'(k_q)) : wt_hold_q;
  assign out_wr_en = (state_q == S_WRITE) && wb_ready;
  assign out_addr  = grp_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);

  fc_delay_line #(.WIDTH(1), .DEPTH(RD_LAT)) u_valid_dly (
    .clock (clock),
    .reset (reset),
    .d_i   (in_rden),
    .q_o   (mac_valid)
  );

  fc_delay_line #(.WIDTH(1), .DEPTH(RD_LAT)) u_sload_dly (
    .clock (clock),
    .reset (reset),
    .d_i   (issue && (k_q == '0)),
    .q_o   (mac_sload)
  );

`ifdef FC_SCHED_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [15:0] perf_stalls_q;

  // Saturating counters, cleared by an accepted start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (busy && (perf_cycles_q != '1)) perf_cycles_q <= perf_cycles_q + 32'd1;
      if ((state_q == S_WRITE) && !wb_ready && (perf_stalls_q != '1))
        perf_stalls_q <= perf_stalls_q + 16'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fc_layer_sched.sv
// Self-checking bench for fc_layer_sched: a schedule model derived from the layer timing rules
// predicts every cycle of a run for directed and randomized wb_ready patterns.
module tb_fc_layer_sched;

  localparam int INNEURON  = 8;
  localparam int OUTNEURON = 4;
  localparam int PO        = 2;
  localparam int RD_LAT    = 2;
  localparam int ACC_LAT   = 1;
  localparam int NB        = INNEURON / 2;
  localparam int NG        = OUTNEURON / PO;
  localparam int DR        = RD_LAT + ACC_LAT;
  localparam int IN_AW     = $clog2(INNEURON);
  localparam int WT_AW     = $clog2(NB * NG);
  localparam int GRP_W     = $clog2(NG + 1);
  localparam int MAXC      = 256;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             wb_ready = 1'b1;
  logic             in_rden, wt_rden, mac_valid, mac_sload, out_wr_en, busy, done;
  logic [IN_AW-1:0] in_addr_a, in_addr_b;
  logic [WT_AW-1:0] wt_addr;
  logic [GRP_W-1:0] out_addr;
`ifdef FC_SCHED_PERF_EN
  logic [31:0]      perf_cycles;
  logic [15:0]      perf_stalls;
`endif

  int total = 0;
  int bad   = 0;

  bit rdy     [MAXC];
  bit e_rden  [MAXC];
  bit e_valid [MAXC];
  bit e_sload [MAXC];
  bit e_wr    [MAXC];
  bit e_busy  [MAXC];
  bit e_done  [MAXC];
  int e_a     [MAXC];
  int e_b     [MAXC];
  int e_wt    [MAXC];
  int e_oaddr [MAXC];
  int fin;
  int stalls;

  fc_layer_sched #(
    .INNEURON (INNEURON),
    .OUTNEURON(OUTNEURON),
    .PO       (PO),
    .RD_LAT   (RD_LAT),
    .ACC_LAT  (ACC_LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .wb_ready  (wb_ready),
    .in_rden   (in_rden),
    .in_addr_a (in_addr_a),
    .in_addr_b (in_addr_b),
    .wt_rden   (wt_rden),
    .wt_addr   (wt_addr),
    .mac_valid (mac_valid),
    .mac_sload (mac_sload),
    .out_wr_en (out_wr_en),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done)
`ifdef FC_SCHED_PERF_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_stalls(perf_stalls)
`endif
  );

  always #5 clock = ~clock;

  // Non-issue busy cycles: addresses frozen at the group's last beat.
  task automatic mark_hold(input int c, input int g);
    e_busy[c] = 1'b1;
    e_a[c]    = 2 * (NB - 1);
    e_b[c]    = 2 * NB - 1;
    e_wt[c]   = g * NB + NB - 1;
  endtask

  // Schedule: start accepted at edge 0; each group issues NB beats, drains DR cycles,
  // then waits in write until wb_ready; the next group issues on the following cycle.
  task automatic build_model();
    int t;
    int w;
    for (int c = 0; c < MAXC; c++) begin
      e_rden[c] = 0; e_valid[c] = 0; e_sload[c] = 0; e_wr[c] = 0;
      e_busy[c] = 0; e_done[c] = 0; e_a[c] = 0; e_b[c] = 0; e_wt[c] = 0; e_oaddr[c] = 0;
    end
    t = 1;
    stalls = 0;
    for (int g = 0; g < NG; g++) begin
      for (int k = 0; k < NB; k++) begin
        e_rden[t+k] = 1'b1;
        e_busy[t+k] = 1'b1;
        e_a[t+k]    = 2 * k;
        e_b[t+k]    = 2 * k + 1;
        e_wt[t+k]   = g * NB + k;
        e_valid[t+k+RD_LAT] = 1'b1;
        if (k == 0) e_sload[t+k+RD_LAT] = 1'b1;
      end
      w = t + NB;
      while ((w < t + NB + DR) || !rdy[w]) begin
        mark_hold(w, g);
        if (w >= t + NB + DR) stalls++;
        w++;
      end
      mark_hold(w, g);
      e_wr[w]    = 1'b1;
      e_oaddr[w] = g;
      t = w + 1;
    end
    mark_hold(t, NG - 1);
    e_done[t] = 1'b1;
    fin = t;
  endtask

  task automatic run_trace(input string tag, input int extra_start);
    int dones;
    logic [6:0] obs_ctl, exp_ctl;
    dones = 0;
    build_model();
    @(negedge clock);
    start = 1'b1;
    wb_ready = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int n = 1; n <= fin + 3; n++) begin
      @(negedge clock);
      wb_ready = rdy[n];
      start = (n == extra_start);
      #1;
      obs_ctl = {in_rden, wt_rden, mac_valid, mac_sload, out_wr_en, busy, done};
      exp_ctl = {e_rden[n], e_rden[n], e_valid[n], e_sload[n], e_wr[n], e_busy[n], e_done[n]};
      total++;
      if (obs_ctl !== exp_ctl) begin
        bad++;
        $display("FAIL %s ctl c%0d rden/wtrden/valid/sload/wr/busy/done got=%b want=%b",
                 tag, n, obs_ctl, exp_ctl);
      end
      if (e_busy[n]) begin
        total++;
        if ((in_addr_a !== IN_AW'(e_a[n])) || (in_addr_b !== IN_AW'(e_b[n])) ||
            (wt_addr !== WT_AW'(e_wt[n]))) begin
          bad++;
          $display("FAIL %s addr c%0d got a=%0d b=%0d wt=%0d want a=%0d b=%0d wt=%0d",
                   tag, n, in_addr_a, in_addr_b, wt_addr, e_a[n], e_b[n], e_wt[n]);
        end
      end
      if (e_wr[n]) begin
        total++;
        if (out_addr !== GRP_W'(e_oaddr[n])) begin
          bad++;
          $display("FAIL %s out_addr c%0d got=%0d want=%0d", tag, n, out_addr, e_oaddr[n]);
        end
      end
      if (done === 1'b1) dones++;
    end
    start = 1'b0;
    wb_ready = 1'b1;
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL %s done_count got=%0d want=1", tag, dones);
    end
`ifdef FC_SCHED_PERF_EN
    total++;
    if (perf_cycles !== 32'(fin)) begin
      bad++;
      $display("FAIL %s perf_cycles got=%0d want=%0d", tag, perf_cycles, fin);
    end
    total++;
    if (perf_stalls !== 16'(stalls)) begin
      bad++;
      $display("FAIL %s perf_stalls got=%0d want=%0d", tag, perf_stalls, stalls);
    end
`endif
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({in_rden, in_addr_a, in_addr_b, wt_rden, wt_addr, mac_valid, mac_sload,
         out_wr_en, out_addr, busy, done} !== '0) begin
      bad++;
      $display("FAIL %s outputs_zero got rden=%b a=%0d b=%0d wtr=%b wt=%0d v=%b s=%b wr=%b oa=%0d busy=%b done=%b want all 0",
               tag, in_rden, in_addr_a, in_addr_b, wt_rden, wt_addr, mac_valid, mac_sload,
               out_wr_en, out_addr, busy, done);
    end
`ifdef FC_SCHED_PERF_EN
    total++;
    if ({perf_cycles, perf_stalls} !== '0) begin
      bad++;
      $display("FAIL %s perf_zero got cycles=%0d stalls=%0d want 0", tag, perf_cycles, perf_stalls);
    end
`endif
  endtask

  task automatic fill_rdy_ones();
    for (int c = 0; c < MAXC; c++) rdy[c] = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clock);
    check_all_zero("reset_clocked");
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    fill_rdy_ones();
    run_trace("nominal", -1);
    total++;
    if (fin != 17) begin
      bad++;
      $display("FAIL nominal model_done_cycle got=%0d want=17", fin);
    end
  endtask

  task automatic test_backpressure();
    fill_rdy_ones();
    for (int c = 8; c <= 10; c++) rdy[c] = 1'b0;
    run_trace("backpressure", -1);
  endtask

  task automatic test_start_ignored();
    fill_rdy_ones();
    run_trace("start_ignored", 5);
  endtask

  task automatic test_reset_mid();
    fill_rdy_ones();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (6) @(negedge clock);
    total++;
    if ({busy, mac_valid} !== 2'b11) begin
      bad++;
      $display("FAIL reset_mid pre_reset busy/valid got=%b want=11", {busy, mac_valid});
    end
    #2 reset = 1'b1;
    #1;
    check_all_zero("reset_mid_async");
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      #1;
      total++;
      if ({out_wr_en, busy, mac_valid} !== 3'b000) begin
        bad++;
        $display("FAIL reset_mid held c%0d wr/busy/valid got=%b want=000", n, {out_wr_en, busy, mac_valid});
      end
    end
    reset = 1'b0;
    run_trace("post_reset", -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < MAXC; c++)
        rdy[c] = (c < 150) ? ($urandom_range(0, 3) != 0) : 1'b1;
      run_trace($sformatf("random%0d", it), (it % 2 == 0) ? int'($urandom_range(1, 15)) : -1);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
